// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester channels, the shared-ALU operand/result path and status
// for alu_arbiter. The arbiter uses the slave modport; requesters and the ALU use master.
//
// Handshake rule for every channel: a transfer happens on the rising clk edge where
// valid and ready are both 1. The source holds valid and its payload stable until then.
interface alu_arbiter_if #(
  parameter int DW   = 4,
  parameter int CW   = 2,
  parameter int OW   = 2,
  parameter int CNTW = 8
);
  logic            req0_valid, req0_ready;
  logic [DW-1:0]   req0_a, req0_b;
  logic [CW-1:0]   req0_c;
  logic [OW-1:0]   req0_op;
  logic            req1_valid, req1_ready;
  logic [DW-1:0]   req1_a, req1_b;
  logic [CW-1:0]   req1_c;
  logic [OW-1:0]   req1_op;
  logic [DW-1:0]   alu_inA, alu_inB, alu_ans;
  logic [CW-1:0]   alu_inC;
  logic [OW-1:0]   alu_op;
  logic            rsp0_valid, rsp0_ready;
  logic [DW-1:0]   rsp0_data;
  logic            rsp1_valid, rsp1_ready;
  logic [DW-1:0]   rsp1_data;
  logic            busy;
  logic [CNTW-1:0] done_cnt0, done_cnt1;
  logic [1:0]      dbgState;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_c, req0_op,
    input  req1_valid, req1_a, req1_b, req1_c, req1_op,
    output req0_ready, req1_ready,
    output alu_inA, alu_inB, alu_inC, alu_op,
    input  alu_ans,
    output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    input  rsp0_ready, rsp1_ready,
    output busy, done_cnt0, done_cnt1, dbgState
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_c, req0_op,
    output req1_valid, req1_a, req1_b, req1_c, req1_op,
    input  req0_ready, req1_ready,
    input  alu_inA, alu_inB, alu_inC, alu_op,
    output alu_ans,
    input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    output rsp0_ready, rsp1_ready,
    input  busy, done_cnt0, done_cnt1, dbgState
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters: accept one
// operation, drive the ALU from registered operands for a cycle, return the result.
module alu_arbiter #(
  parameter int DW   = 4,
  parameter int CW   = 2,
  parameter int OW   = 2,
  parameter int CNTW = 8
) (
  input logic          clk,
  input logic          reset,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic            owner;
  logic            lastGrant;
  logic            grant0, grant1;
  logic [DW-1:0]   selA, selB;
  logic [CW-1:0]   selC;
  logic [OW-1:0]   selOp;
  logic [CNTW-1:0] doneCnt0, doneCnt1;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = lastGrant;
        grant1 = !lastGrant;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
    selA  = grant1 ? bus.req1_a  : bus.req0_a;
    selB  = grant1 ? bus.req1_b  : bus.req0_b;
    selC  = grant1 ? bus.req1_c  : bus.req0_c;
    selOp = grant1 ? bus.req1_op : bus.req0_op;
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.busy       = (state != IDLE);
  assign bus.done_cnt0  = doneCnt0;
  assign bus.done_cnt1  = doneCnt1;
  assign bus.dbgState   = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      owner          <= 1'b0;
      lastGrant      <= 1'b1;
      bus.alu_inA    <= '0;
      bus.alu_inB    <= '0;
      bus.alu_inC    <= '0;
      bus.alu_op     <= '0;
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      bus.rsp0_data  <= '0;
      bus.rsp1_data  <= '0;
      doneCnt0       <= '0;
      doneCnt1       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            bus.alu_inA <= selA;
            bus.alu_inB <= selB;
            bus.alu_inC <= selC;
            bus.alu_op  <= selOp;
            owner       <= grant1;
            lastGrant   <= grant1;
            state       <= EXEC;
          end
        end
        EXEC: begin
          // The per-port data register doubles as the result capture.
          if (owner) begin
            bus.rsp1_valid <= 1'b1;
            bus.rsp1_data  <= bus.alu_ans;
          end else begin
            bus.rsp0_valid <= 1'b1;
            bus.rsp0_data  <= bus.alu_ans;
          end
          state <= RESP;
        end
        RESP: begin
          if (owner && bus.rsp1_ready) begin
            bus.rsp1_valid <= 1'b0;
            doneCnt1       <= doneCnt1 + 1'b1;
            state          <= IDLE;
          end else if (!owner && bus.rsp0_ready) begin
            bus.rsp0_valid <= 1'b0;
            doneCnt0       <= doneCnt0 + 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, multi-cycle corner sequences and a
// randomized phase, all judged by a transaction-level model of the arbitration rules.
module tb_alu_arbiter;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  alu_arbiter_if #(.DW(4), .CW(2), .OW(2), .CNTW(8)) bus ();

  alu_arbiter #(.DW(4), .CW(2), .OW(2), .CNTW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Example ALU: add, subtract, xor, shift-left by inC.
  function automatic logic [3:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] c, input logic [1:0] op);
    logic [3:0] r;
    case (op)
      2'd0:    r = a + b;
      2'd1:    r = a - b;
      2'd2:    r = a ^ b;
      default: r = a << c;
    endcase
    return r;
  endfunction

  assign bus.alu_ans = alu_ref(bus.alu_inA, bus.alu_inB, bus.alu_inC, bus.alu_op);

  task automatic check(input logic [31:0] act, input logic [31:0] exp, input string name);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_req(input bit p, input bit v, input logic [3:0] a, input logic [3:0] b,
                           input logic [1:0] c, input logic [1:0] op);
    if (p) begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_c = c; bus.req1_op = op;
    end else begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_c = c; bus.req0_op = op;
    end
  endtask

  task automatic drive_rand(input bit p, input bit v);
    drive_req(p, v, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
  endtask

  // Waits (bounded) at negedges until the arbiter is idle.
  task automatic wait_idle(input string name);
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) break;
    end
    check(bus.busy, 0, name);
  endtask

  // One op with rsp_ready already 1; starts and ends at a negedge in IDLE.
  task automatic run_op(input bit p, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] c, input logic [1:0] op, input logic [3:0] exp);
    drive_req(p, 1'b1, a, b, c, op);
    #1;
    check(p ? bus.req1_ready : bus.req0_ready, 1, "op_ready");
    @(negedge clk);
    drive_req(p, 1'b0, a, b, c, op);
    #1;
    check({bus.alu_inA, bus.alu_inB, bus.alu_inC, bus.alu_op}, {a, b, c, op}, "alu_operands");
    check(bus.busy, 1, "exec_busy");
    @(negedge clk);
    #1;
    check(p ? bus.rsp1_valid : bus.rsp0_valid, 1, "rsp_valid");
    check(p ? bus.rsp1_data : bus.rsp0_data, exp, "rsp_data");
    check(p ? bus.rsp0_valid : bus.rsp1_valid, 0, "rsp_other_quiet");
    @(negedge clk);
  endtask

  // Transaction-level reference: one outstanding op, response due two cycles after
  // accept, results per port in order, completion counts per port.
  logic [3:0] exp_q0[$];
  logic [3:0] exp_q1[$];
  bit         outstanding;
  bit         owner_m;
  bit         last_m;
  int         since_acc;
  logic [7:0] cnt0_m, cnt1_m;

  always begin
    bit g0, g1;
    @(negedge clk);
    #2;
    if (reset === 1'b0) begin
      exp_q0.delete();
      exp_q1.delete();
      outstanding = 0;
      owner_m     = 0;
      last_m      = 1;
      since_acc   = 0;
      cnt0_m      = 0;
      cnt1_m      = 0;
    end else begin
      if (outstanding) since_acc++;
      check(bus.busy, outstanding, "mon_busy");
      check(bus.done_cnt0, cnt0_m, "mon_done_cnt0");
      check(bus.done_cnt1, cnt1_m, "mon_done_cnt1");
      check(bus.rsp0_valid, outstanding && !owner_m && since_acc >= 2, "mon_rsp0_valid");
      check(bus.rsp1_valid, outstanding && owner_m && since_acc >= 2, "mon_rsp1_valid");
      if (bus.rsp0_valid === 1'b1 && exp_q0.size() > 0) check(bus.rsp0_data, exp_q0[0], "mon_rsp0_data");
      if (bus.rsp1_valid === 1'b1 && exp_q1.size() > 0) check(bus.rsp1_data, exp_q1[0], "mon_rsp1_data");
      g0 = !outstanding && bus.req0_valid && (!bus.req1_valid || last_m);
      g1 = !outstanding && bus.req1_valid && (!bus.req0_valid || !last_m);
      check(bus.req0_ready, g0, "mon_req0_ready");
      check(bus.req1_ready, g1, "mon_req1_ready");
      if (outstanding && since_acc >= 2) begin
        if (!owner_m && bus.rsp0_ready) begin
          if (exp_q0.size() > 0) void'(exp_q0.pop_front());
          cnt0_m++;
          outstanding = 0;
        end else if (owner_m && bus.rsp1_ready) begin
          if (exp_q1.size() > 0) void'(exp_q1.pop_front());
          cnt1_m++;
          outstanding = 0;
        end
      end
      if (g0 || g1) begin
        if (g1) exp_q1.push_back(alu_ref(bus.req1_a, bus.req1_b, bus.req1_c, bus.req1_op));
        else    exp_q0.push_back(alu_ref(bus.req0_a, bus.req0_b, bus.req0_c, bus.req0_op));
        outstanding = 1;
        owner_m     = g1;
        last_m      = g1;
        since_acc   = 0;
      end
    end
  end

  typedef struct {
    bit         port;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] c;
    logic [1:0] op;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[10];
  int   grants[$];

  initial begin
    bit r0, r1, pend0, pend1;

    vecs[0] = '{1'b0, 4'b1110, 4'b0101, 2'b10, 2'b00, 4'b0011};
    vecs[1] = '{1'b1, 4'b1110, 4'b0101, 2'b10, 2'b00, 4'b0011};
    vecs[2] = '{1'b1, 4'b1110, 4'b0101, 2'b10, 2'b01, 4'b1001};
    vecs[3] = '{1'b1, 4'b1110, 4'b0101, 2'b10, 2'b10, 4'b1011};
    vecs[4] = '{1'b1, 4'b1110, 4'b0101, 2'b10, 2'b11, 4'b1000};
    vecs[5] = '{1'b0, 4'b1111, 4'b0001, 2'b00, 2'b00, 4'b0000};
    vecs[6] = '{1'b0, 4'b0000, 4'b0001, 2'b00, 2'b01, 4'b1111};
    vecs[7] = '{1'b1, 4'b0011, 4'b0000, 2'b11, 2'b11, 4'b1000};
    vecs[8] = '{1'b0, 4'b1010, 4'b1010, 2'b01, 2'b10, 4'b0000};
    vecs[9] = '{1'b1, 4'b0110, 4'b0011, 2'b01, 2'b11, 4'b1100};

    reset = 1'b0;
    drive_req(0, 0, 0, 0, 0, 0);
    drive_req(1, 0, 0, 0, 0, 0);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check(bus.busy, 0, "rst_busy");
    check({bus.rsp0_valid, bus.rsp1_valid}, 0, "rst_rsp_valid");
    check({bus.rsp0_data, bus.rsp1_data}, 0, "rst_rsp_data");
    check({bus.alu_inA, bus.alu_inB, bus.alu_inC, bus.alu_op}, 0, "rst_alu");
    check({bus.done_cnt0, bus.done_cnt1}, 0, "rst_counts");
    check({bus.req0_ready, bus.req1_ready}, 0, "rst_ready");
    reset = 1'b1;
    @(negedge clk);

    // Vector table: single op, op sweep on port 1, assorted boundary operands
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].op, vecs[i].exp);
      if (i == 0) check(bus.done_cnt0, 1, "single_done_cnt0");
      if (i == 4) check(bus.done_cnt1, 4, "sweep_done_cnt1");
    end

    // Contention from a fresh reset: grants must alternate starting with port 0
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    drive_rand(0, 1'b1);
    drive_rand(1, 1'b1);
    for (int cyc = 0; cyc < 60 && grants.size() < 6; cyc++) begin
      #1;
      r0 = bus.req0_ready;
      r1 = bus.req1_ready;
      if (r0) grants.push_back(0);
      if (r1) grants.push_back(1);
      @(negedge clk);
      if (r0) drive_rand(0, grants.size() < 6);
      if (r1) drive_rand(1, grants.size() < 6);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check(grants.size(), 6, "contention_grants");
    foreach (grants[i]) check(grants[i], i % 2, "grant_order");
    wait_idle("contention_idle");
    check(bus.done_cnt0, 3, "contention_cnt0");
    check(bus.done_cnt1, 3, "contention_cnt1");

    // Backpressure on port 0 while port 1 waits
    bus.rsp0_ready = 1'b0;
    drive_req(0, 1'b1, 4'h7, 4'h2, 2'd1, 2'd1);
    #1;
    check(bus.req0_ready, 1, "bp_accept0");
    @(negedge clk);
    drive_req(0, 1'b0, 4'h7, 4'h2, 2'd1, 2'd1);
    drive_req(1, 1'b1, 4'h3, 4'h4, 2'd0, 2'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      check(bus.rsp0_valid, 1, "bp_valid");
      check(bus.rsp0_data, 4'h5, "bp_data");
      check(bus.req1_ready, 0, "bp_req1_held");
      @(negedge clk);
    end
    bus.rsp0_ready = 1'b1;
    #1;
    check(bus.rsp0_valid, 1, "bp_valid_release");
    check(bus.req1_ready, 0, "bp_req1_release");
    @(negedge clk);
    #1;
    check(bus.req1_ready, 1, "bp_req1_next_idle");
    @(negedge clk);
    bus.req1_valid = 1'b0;
    wait_idle("bp_idle");

    // Reset during EXEC discards the op
    drive_req(0, 1'b1, 4'h9, 4'h1, 2'd0, 2'd0);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check(bus.busy, 0, "midrst_busy");
    check({bus.rsp0_valid, bus.rsp1_valid}, 0, "midrst_rsp_valid");
    check({bus.done_cnt0, bus.done_cnt1}, 0, "midrst_counts");
    repeat (4) @(negedge clk);
    #1;
    check({bus.rsp0_valid, bus.rsp1_valid}, 0, "midrst_no_late_rsp");
    @(negedge clk);

    // Counter wrap on port 0
    for (int i = 0; i < 256; i++) begin
      logic [3:0] a, b;
      logic [1:0] c, op;
      a  = 4'($urandom_range(0, 15));
      b  = 4'($urandom_range(0, 15));
      c  = 2'($urandom_range(0, 3));
      op = 2'($urandom_range(0, 3));
      run_op(1'b0, a, b, c, op, alu_ref(a, b, c, op));
      if (i == 254) check(bus.done_cnt0, 255, "cnt_255");
    end
    check(bus.done_cnt0, 0, "cnt_wrap");

    // Randomized traffic with random response backpressure
    pend0 = 0;
    pend1 = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (pend0) bus.req0_valid = 1'b0;
      if (pend1) bus.req1_valid = 1'b0;
      if (!bus.req0_valid && $urandom_range(0, 2) == 0) drive_rand(0, 1'b1);
      if (!bus.req1_valid && $urandom_range(0, 2) == 0) drive_rand(1, 1'b1);
      bus.rsp0_ready = 1'($urandom_range(0, 1));
      bus.rsp1_ready = 1'($urandom_range(0, 1));
      #1;
      pend0 = bus.req0_valid && bus.req0_ready;
      pend1 = bus.req1_valid && bus.req1_ready;
      @(negedge clk);
    end
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (pend0) bus.req0_valid = 1'b0;
      if (pend1) bus.req1_valid = 1'b0;
      if (!bus.req0_valid && !bus.req1_valid) break;
      #1;
      pend0 = bus.req0_valid && bus.req0_ready;
      pend1 = bus.req1_valid && bus.req1_ready;
      @(negedge clk);
    end
    check({bus.req0_valid, bus.req1_valid}, 0, "drain_requests");
    wait_idle("drain_idle");
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
